// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//  Signal bundle between the IF/MEM requesters, the port arbiter and the
//  single data RAM port.
//  Modports:
//   slave  - the arbiter. It takes the requests and the RAM read data, and
//            drives the acks, read data, stall, and the RAM port controls.
//   master - the environment: the IF/MEM stages plus the RAM macro.
//  Signals:
//   i_req/i_addr/i_ack/i_rdata                  instruction fetch port (read-only)
//   d_req/d_we/d_sel/d_addr/d_wdata/d_ack/d_rdata  MEM stage data port
//   stall_o                                     pending-request stall to the pipeline
//   ram_en/ram_wr/ram_sel/ram_addr/ram_wdata    to the RAM macro
//   ram_rdata                                   from the RAM macro (combinational)
interface ram_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [3:0]    d_sel;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          stall_o;

  logic          ram_en;
  logic          ram_wr;
  logic [3:0]    ram_sel;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, ram_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, stall_o,
           ram_en, ram_wr, ram_sel, ram_addr, ram_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, ram_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, stall_o,
           ram_en, ram_wr, ram_sel, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//  Shares the single byte-lane data RAM port between instruction fetch (I,
//  read-only) and the MEM stage (D, read/write). A registered grant FSM
//  (IDLE / GNT_I / GNT_D) owns the RAM for one cycle per grant. The
//  requester then gets a one-cycle ack pulse together with the registered
//  read data. D has priority out of IDLE. A burst counter stops D from
//  starving a pending fetch.
//  Ports:
//   clk  - clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - ram_port_arbiter_if.slave (request ports, stall, RAM port)
module ram_port_arbiter #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_arbiter_if.slave    bus
);

  // RAM wr_en encoding.
  localparam logic RAM_WRITE = 1'b1;
  localparam logic RAM_READ  = 1'b0;

  localparam int CW = $clog2(MAX_D_BURST + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t        state, state_nxt;
  logic          i_ack_q, d_ack_q;
  logic [DW-1:0] i_rdata_q, d_rdata_q;
  logic [CW-1:0] burst_cnt;
  logic          lat_wr;
  logic [3:0]    lat_sel;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic i_elig, d_elig, burst_full, grant_i, grant_d;

  // The ack cycle never counts as a fresh request from the same requester.
  assign i_elig     = bus.i_req & ~i_ack_q;
  assign d_elig     = bus.d_req & ~d_ack_q;
  assign burst_full = (burst_cnt == CW'(MAX_D_BURST));

  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE: begin
        if (i_elig && d_elig) state_nxt = burst_full ? GNT_I : GNT_D;
        else if (d_elig)      state_nxt = GNT_D;
        else if (i_elig)      state_nxt = GNT_I;
      end
      // A grant never repeats for the same requester, which gives strict
      // alternation when both sides keep requesting.
      GNT_I: if (d_elig) state_nxt = GNT_D;
      GNT_D: if (i_elig) state_nxt = GNT_I;
      default: state_nxt = IDLE;
    endcase
  end

  // GNT_x never follows GNT_x, so entering a grant state is simply next == GNT_x.
  assign grant_i = (state_nxt == GNT_I);
  assign grant_d = (state_nxt == GNT_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      burst_cnt <= '0;
      lat_wr    <= RAM_READ;
      lat_sel   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state   <= state_nxt;
      i_ack_q <= (state == GNT_I);
      d_ack_q <= (state == GNT_D);

      if (state == GNT_I)                        i_rdata_q <= bus.ram_rdata;
      if (state == GNT_D && lat_wr == RAM_READ)  d_rdata_q <= bus.ram_rdata;

      // Request fields are frozen at the grant edge. Later changes are ignored.
      if (grant_d) begin
        lat_wr    <= bus.d_we ? RAM_WRITE : RAM_READ;
        lat_sel   <= bus.d_sel;
        lat_addr  <= bus.d_addr;
        lat_wdata <= bus.d_wdata;
      end else if (grant_i) begin
        lat_wr    <= RAM_READ;
        lat_sel   <= 4'hF;
        lat_addr  <= bus.i_addr;
      end

      // Counts D grants taken while a fetch waits. Saturates at the limit.
      if (grant_i || !i_elig)           burst_cnt <= '0;
      else if (grant_d && !burst_full)  burst_cnt <= burst_cnt + 1'b1;
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_o   = (bus.i_req & ~i_ack_q) | (bus.d_req & ~d_ack_q);
  assign bus.ram_en    = (state != IDLE);
  assign bus.ram_wr    = (state != IDLE) ? lat_wr : RAM_READ;
  assign bus.ram_sel   = lat_sel;
  assign bus.ram_addr  = lat_addr;
  assign bus.ram_wdata = lat_wdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  logic preload;

  ram_port_arbiter_if #(.DW(DW), .AW(AW)) bus();

  ram_port_arbiter #(.DW(DW), .AW(AW), .MAX_D_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // RAM macro model: combinational read, byte-lane write on the clock edge.
  logic [31:0] mem [64];
  logic [31:0] shadow [64];

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'hAAAAAAAA;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                       input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  assign bus.ram_rdata = mem[bus.ram_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bus.ram_en && bus.ram_wr) begin
      mem[bus.ram_addr[7:2]] <= merge(mem[bus.ram_addr[7:2]], bus.ram_wdata, bus.ram_sel);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input logic cond);
    n_chk++;
    if (cond !== 1'b1) begin
      n_err++;
      $display("FAIL %s: condition false", name);
    end
  endtask

  // One D access from an idle arbiter: grant in cycle 1, ack in cycle 2.
  task automatic d_access(input string tag, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_sel = sel;
    bus.d_addr = addr; bus.d_wdata = wdata;
    #1 chk({tag, "_stall"}, 32'(bus.stall_o), 32'd1);
    @(negedge clk);
    chk({tag, "_ram_en"},  32'(bus.ram_en), 32'd1);
    chk({tag, "_ram_wr"},  32'(bus.ram_wr), 32'(we));
    chk({tag, "_ram_sel"}, 32'(bus.ram_sel), 32'(sel));
    chk({tag, "_ram_addr"}, bus.ram_addr, addr);
    if (we) chk({tag, "_ram_wdata"}, bus.ram_wdata, wdata);
    chk({tag, "_early_ack"}, 32'(bus.d_ack), 32'd0);
    @(negedge clk);
    chk({tag, "_ack"}, 32'(bus.d_ack), 32'd1);
    chk({tag, "_rdata"}, bus.d_rdata, exp_rd);
    bus.d_req = 1'b0;
    if (we) shadow[addr[7:2]] = merge(shadow[addr[7:2]], wdata, sel);
    @(negedge clk);
    chk({tag, "_ack_pulse"}, 32'(bus.d_ack), 32'd0);
  endtask

  // Per-cycle traffic driver; data checked against the shadow memory, which
  // is updated in ack order (accesses to the single port are serialised).
  task automatic traffic(input string tag, input int cycles, input int pct_i, input int pct_d,
                         output int n_iack, output int n_dack);
    int i_wait, d_wait, d_run;
    i_wait = 0; d_wait = 0; d_run = 0; n_iack = 0; n_dack = 0;
    for (int c = 0; c < cycles + 60; c++) begin
      @(negedge clk);
      if (bus.i_ack) begin
        chk({tag, "_i_rdata"}, bus.i_rdata, shadow[bus.i_addr[7:2]]);
        bus.i_req = 1'b0; i_wait = 0; d_run = 0; n_iack++;
      end
      if (bus.d_ack) begin
        if (bus.d_we)
          shadow[bus.d_addr[7:2]] = merge(shadow[bus.d_addr[7:2]], bus.d_wdata, bus.d_sel);
        else
          chk({tag, "_d_rdata"}, bus.d_rdata, shadow[bus.d_addr[7:2]]);
        bus.d_req = 1'b0; d_wait = 0; n_dack++;
        if (bus.i_req) begin
          d_run++;
          chk_true({tag, "_d_burst_bound"}, d_run <= MAXB);
        end
      end
      if (bus.i_req) begin
        i_wait++;
        if (i_wait > 16) begin
          n_chk++; n_err++;
          $display("FAIL %s_i_timeout: no i_ack after %0d cycles", tag, i_wait);
          bus.i_req = 1'b0; i_wait = 0;
        end
      end
      if (bus.d_req) begin
        d_wait++;
        if (d_wait > 16) begin
          n_chk++; n_err++;
          $display("FAIL %s_d_timeout: no d_ack after %0d cycles", tag, d_wait);
          bus.d_req = 1'b0; d_wait = 0;
        end
      end
      if (c >= cycles && !bus.i_req && !bus.d_req) break;
      if (c < cycles) begin
        if (!bus.i_req && $urandom_range(99) < 32'(pct_i)) begin
          bus.i_req = 1'b1;
          bus.i_addr = 32'($urandom_range(63)) << 2;
          d_run = 0;
        end
        if (!bus.d_req && $urandom_range(99) < 32'(pct_d)) begin
          bus.d_req = 1'b1;
          bus.d_we = 1'($urandom_range(1));
          bus.d_sel = 4'($urandom_range(15));
          bus.d_addr = 32'($urandom_range(63)) << 2;
          bus.d_wdata = $urandom;
        end
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } dvec_t;

  dvec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ni, nd, waited, cyc, last_cyc;
    logic [31:0] a0, a1;

    vecs[0] = '{1'b0, 4'hF, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 4'h3, 32'h20, 32'h11223344, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 4'hF, 32'h20, 32'h0,        32'hAAAA3344};
    vecs[3] = '{1'b1, 4'hC, 32'h24, 32'h55667788, 32'hAAAA3344};
    vecs[4] = '{1'b0, 4'hF, 32'h24, 32'h0,        32'h55660909};
    vecs[5] = '{1'b1, 4'hF, 32'h28, 32'hCAFEF00D, 32'h55660909};
    vecs[6] = '{1'b0, 4'hF, 32'h28, 32'h0,        32'hCAFEF00D};
    vecs[7] = '{1'b1, 4'h0, 32'h2C, 32'hFFFFFFFF, 32'hCAFEF00D};
    vecs[8] = '{1'b0, 4'hF, 32'h2C, 32'h0,        32'h100B0B0B};

    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);

    rst = 1'b1; preload = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_sel = '0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    chk("reset_i_ack",   32'(bus.i_ack), 32'd0);
    chk("reset_d_ack",   32'(bus.d_ack), 32'd0);
    chk("reset_i_rdata", bus.i_rdata, 32'd0);
    chk("reset_d_rdata", bus.d_rdata, 32'd0);
    chk("reset_ram_en",  32'(bus.ram_en), 32'd0);
    chk("reset_stall",   32'(bus.stall_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ram_en", 32'(bus.ram_en), 32'd0);

    // Directed D accesses: reads, byte-lane writes, unchanged d_rdata on writes.
    for (int k = 0; k < 9; k++)
      d_access($sformatf("vec%0d", k), vecs[k].we, vecs[k].sel, vecs[k].addr,
               vecs[k].wdata, vecs[k].exp_rd);

    // Simultaneous I and D from idle: D first, I right behind it.
    a0 = 32'h10; a1 = 32'h20;
    bus.i_req = 1'b1; bus.i_addr = a0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_sel = 4'hF; bus.d_addr = a1;
    @(negedge clk);
    chk("both_c1_ram_en",   32'(bus.ram_en), 32'd1);
    chk("both_c1_ram_addr", bus.ram_addr, a1);
    @(negedge clk);
    chk("both_c2_d_ack",    32'(bus.d_ack), 32'd1);
    chk("both_c2_d_rdata",  bus.d_rdata, shadow[a1[7:2]]);
    chk("both_c2_i_ack",    32'(bus.i_ack), 32'd0);
    chk("both_c2_ram_addr", bus.ram_addr, a0);
    chk("both_c2_ram_wr",   32'(bus.ram_wr), 32'd0);
    chk("both_c2_ram_sel",  32'(bus.ram_sel), 32'hF);
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("both_c3_i_ack",   32'(bus.i_ack), 32'd1);
    chk("both_c3_i_rdata", bus.i_rdata, shadow[a0[7:2]]);
    chk("both_c3_d_ack",   32'(bus.d_ack), 32'd0);
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("both_c4_i_ack", 32'(bus.i_ack), 32'd0);

    // Reset in the middle of a D write grant.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_sel = 4'hF;
    bus.d_addr = 32'h30; bus.d_wdata = 32'h0BADC0DE;
    @(negedge clk);
    chk("rstmid_ram_en_before", 32'(bus.ram_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_ram_en",  32'(bus.ram_en), 32'd0);
    chk("rstmid_d_ack",   32'(bus.d_ack), 32'd0);
    chk("rstmid_d_rdata", bus.d_rdata, 32'd0);
    chk("rstmid_i_rdata", bus.i_rdata, 32'd0);
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("rstmid_no_ack", 32'(bus.d_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    d_access("rstmid_redo_wr", 1'b1, 4'hF, 32'h30, 32'h0BADC0DE, 32'h0);
    d_access("rstmid_redo_rd", 1'b0, 4'hF, 32'h30, 32'h0, 32'h0BADC0DE);

    // Fetch stream 0x00..0x1C with i_req held throughout.
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    cyc = 0; last_cyc = 0;
    for (int k = 0; k < 8; k++) begin
      waited = 0;
      do begin
        @(negedge clk);
        cyc++; waited++;
      end while (!bus.i_ack && waited < 8);
      if (!bus.i_ack) begin
        n_chk++; n_err++;
        $display("FAIL fetch%0d_timeout: no i_ack within %0d cycles", k, waited);
        break;
      end
      chk($sformatf("fetch%0d_rdata", k), bus.i_rdata, shadow[k]);
      if (k == 0) chk("fetch0_latency", 32'(waited), 32'd2);
      else        chk_true($sformatf("fetch%0d_gap", k), (cyc - last_cyc) >= 2 && (cyc - last_cyc) <= 3);
      last_cyc = cyc;
      if (k < 7) bus.i_addr = 32'((k + 1) * 4);
      else       bus.i_req = 1'b0;
    end
    @(negedge clk);

    // Both requesters held continuously: fetch must keep being served.
    traffic("held", 40, 100, 100, ni, nd);
    chk_true("held_i_served", ni >= 8);
    chk_true("held_d_served", nd >= 8);
    chk_true("held_i_share", ni * (MAXB + 1) >= nd);

    // Random mixed traffic against the shadow memory.
    traffic("rand", 600, 40, 50, ni, nd);
    chk_true("rand_i_served", ni > 0);
    chk_true("rand_d_served", nd > 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
